// File: rtl/rx_descrambler.sv
// rtl/rx_descrambler.sv - 802.11a receive descrambler with SERVICE-field seed recovery
//
// Purpose:
//   Receives the serial bit stream from the Viterbi decoder. The scrambler state
//   is recovered from SERVICE bits 0-6, which are transmitted as zeros.
//   The rest of the frame is descrambled with the x^7 + x^4 + 1 LFSR.
//   The 16 SERVICE bits are stripped and PSDU bits are emitted one per valid cycle.
//
// Ports:
//   Clk          in   1  system clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   start        in   1  next accepted bit (same cycle included) is SERVICE bit 0
//   stop         in   1  end of frame, return to IDLE
//   in_valid     in   1  in_data qualifier
//   in_data      in   1  scrambled bit from the decoder
//   out_valid    out  1  descrambled PSDU bit valid
//   out_data     out  1  descrambled PSDU bit
//   sync_state   out  7  LFSR state captured after SERVICE bit 6
//   seed_valid   out  1  sync_state valid for the current frame
//   service_err  out  1  sticky: a reserved SERVICE bit descrambled to 1
//   busy         out  1  high in any state except IDLE
//
// Configuration:
//   RX_DESCRAMBLER_SERVICE_CHECK_EN  when defined, compiles in the reserved SERVICE
//                                    bit check. When undefined, service_err is tied to 0.

module rx_descrambler (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       out_valid,
  output logic       out_data,
  output logic [6:0] sync_state,
  output logic       seed_valid,
  output logic       service_err,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  logic [1:0] state;
  logic [6:0] lfsr;
  logic [3:0] bitcnt;
  logic       fb;

  assign fb = lfsr[6] ^ lfsr[3];

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      lfsr       <= 7'd0;
      bitcnt     <= 4'd0;
      sync_state <= 7'd0;
      seed_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        // A bit arriving with start is SERVICE bit 0, so it is already shifted in.
        state      <= ST_ACQ;
        busy       <= 1'b1;
        seed_valid <= 1'b0;
        if (in_valid) begin
          lfsr   <= {6'd0, in_data};
          bitcnt <= 4'd1;
        end else begin
          lfsr   <= 7'd0;
          bitcnt <= 4'd0;
        end
      end else if (stop) begin
        // Any bit presented alongside stop is dropped.
        // sync_state and the flags keep their values.
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (in_valid) begin
        case (state)
          ST_ACQ: begin
            // SERVICE bits 0-6 are scrambled zeros.
            // The received bits are therefore the TX LFSR state itself.
            lfsr   <= {lfsr[5:0], in_data};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd6) begin
              sync_state <= {lfsr[5:0], in_data};
              seed_valid <= 1'b1;
              state      <= ST_SVC;
            end
          end
          ST_SVC: begin
            lfsr   <= {lfsr[5:0], fb};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd15) begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            out_data  <= in_data ^ fb;
            out_valid <= 1'b1;
            lfsr      <= {lfsr[5:0], fb};
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef RX_DESCRAMBLER_SERVICE_CHECK_EN
  // A reserved SERVICE bit (7-15) that does not descramble to zero
  // indicates a seed or decode error.
  logic svc_bad;

  assign svc_bad = !start && !stop && in_valid && (state == ST_SVC) && (in_data ^ fb);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      service_err <= 1'b0;
    end else if (start) begin
      service_err <= 1'b0;
    end else if (svc_bad) begin
      service_err <= 1'b1;
    end
  end
`else
  assign service_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_descrambler.sv
// tb/tb_rx_descrambler.sv - scoreboard testbench for rx_descrambler

module tb_rx_descrambler;

  logic       Clk;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       in_valid;
  logic       in_data;
  logic       out_valid;
  logic       out_data;
  logic [6:0] sync_state;
  logic       seed_valid;
  logic       service_err;
  logic       busy;

`ifdef RX_DESCRAMBLER_SERVICE_CHECK_EN
  localparam bit SVC_CHK = 1'b1;
`else
  localparam bit SVC_CHK = 1'b0;
`endif

  localparam logic [15:0] SVC_ONES = 16'b0000111_011110010;
  localparam logic [63:0] PAT_A    = 64'hA5C3_1F08_7E92_D46B;
  localparam logic [63:0] PAT_B    = 64'h3C96_E1F0_5A0F_C387;

  rx_descrambler dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .sync_state  (sync_state),
    .seed_valid  (seed_valid),
    .service_err (service_err),
    .busy        (busy)
  );

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   ov_count  = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  bit   lat_armed = 0;
  logic exp_q[$];
  logic tx_bits[$];
  logic data_bits[$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial forever begin
    @(posedge Clk);
    cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented PSDU bit is matched against the queue head.
  initial forever begin
    @(negedge Clk);
    if (reset_n && out_valid) begin
      ov_count++;
      if (lat_armed) begin
        lat_armed = 0;
        check("first_out_latency", cyc - start_cyc, 17);
      end
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check("out_data", int'(out_data), int'(e));
      end
    end
  end

  task automatic drive(input logic st, input logic sp, input logic v, input logic d);
    start    = st;
    stop     = sp;
    in_valid = v;
    in_data  = d;
    @(posedge Clk);
    #1;
    start    = 1'b0;
    stop     = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
  endtask

  // TX-side reference: scramble 16 zero SERVICE bits and then ndata payload bits.
  // Bit index flip is inverted after scrambling.
  task automatic build_frame(input logic [6:0] seed, input logic [63:0] pat,
                             input int ndata, input int flip);
    logic [6:0] s;
    logic       plain;
    logic       f;
    logic       b;
    tx_bits.delete();
    data_bits.delete();
    s = seed;
    for (int i = 0; i < 16 + ndata; i++) begin
      plain = (i < 16) ? 1'b0 : pat[63 - (i - 16)];
      f     = s[6] ^ s[3];
      b     = plain ^ f;
      s     = {s[5:0], f};
      if (i == flip) b = ~b;
      tx_bits.push_back(b);
      if (i >= 16) data_bits.push_back(plain);
    end
  endtask

  task automatic send_frame(input bit gap3, input int nbits, input bit with_stop, input int flip);
    int idx;
    int k;
    idx = 0;
    k   = 0;
    while (idx < nbits) begin
      if (gap3 && (k % 3 == 2)) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        if (idx >= 16) exp_q.push_back(data_bits[idx - 16]);
        if (idx == 0) start_cyc = cyc;
        drive(idx == 0, (idx == 0) && with_stop, 1'b1, tx_bits[idx]);
        check("seed_valid_progress", int'(seed_valid), int'(idx >= 6));
        check("service_err_progress", int'(service_err),
              int'(SVC_CHK && flip >= 7 && flip < 16 && idx >= flip));
        check("busy_in_frame", int'(busy), 1);
        idx++;
      end
      k++;
    end
  endtask

  task automatic drain(input int exp_count, input string name);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_out_count"}, ov_count, exp_count);
    check({name, "_busy_after_stop"}, int'(busy), 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_sync_state", int'(sync_state), 0);
    check("rst_seed_valid", int'(seed_valid), 0);
    check("rst_service_err", int'(service_err), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;

    // Input before any start is ignored.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'(i & 1));
    check("idle_ignore_busy", int'(busy), 0);
    check("idle_ignore_out", ov_count, 0);

    // Seed recovery with the all-ones seed.
    tx_bits.delete();
    data_bits.delete();
    for (int i = 0; i < 16; i++) begin
      logic b;
      b = SVC_ONES[15 - i];
      tx_bits.push_back(b);
    end
    ov_count = 0;
    send_frame(1'b0, 16, 1'b0, -1);
    check("ones_sync_state", int'(sync_state), int'(7'b0000111));
    check("ones_service_err", int'(service_err), 0);
    check("ones_no_out_valid", ov_count, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("stop_busy_low", int'(busy), 0);
    check("stop_seed_valid_held", int'(seed_valid), 1);
    check("stop_sync_state_held", int'(sync_state), int'(7'b0000111));

    // Continuous round trip, seed 1011101, with latency measured on the first PSDU bit.
    build_frame(7'b1011101, PAT_A, 64, -1);
    ov_count  = 0;
    lat_armed = 1;
    send_frame(1'b0, 80, 1'b0, -1);
    check("rt_sync_state", int'(sync_state), int'(7'b0110110));
    drain(64, "roundtrip");
    check("rt_latency_seen", int'(lat_armed), 0);

    // The same stream with in_valid dropped every third cycle.
    ov_count = 0;
    send_frame(1'b1, 80, 1'b0, -1);
    drain(64, "gapped");

    // Reserved SERVICE bit 10 corrupted.
    build_frame(7'b1011101, PAT_A, 64, 10);
    ov_count = 0;
    send_frame(1'b0, 80, 1'b0, 10);
    drain(64, "svc_err");
    check("svc_err_held_after_stop", int'(service_err), int'(SVC_CHK));

    // Restart mid-DATA of a corrupted frame with a new frame's bit 0.
    ov_count = 0;
    send_frame(1'b0, 36, 1'b0, 10);
    build_frame(7'b1111111, PAT_B, 32, -1);
    send_frame(1'b0, 48, 1'b0, -1);
    check("restart_sync_state", int'(sync_state), int'(7'b0000111));
    drain(52, "restart");

    // stop and start in the same cycle enter ACQ.
    build_frame(7'b1011101, PAT_B, 16, -1);
    ov_count = 0;
    send_frame(1'b0, 32, 1'b1, -1);
    check("stopstart_sync_state", int'(sync_state), int'(7'b0110110));
    drain(16, "stopstart");

    // Asynchronous reset between edges in the middle of DATA.
    build_frame(7'b1011101, PAT_A, 64, -1);
    ov_count = 0;
    send_frame(1'b0, 26, 1'b0, -1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_data", int'(out_data), 0);
    check("arst_sync_state", int'(sync_state), 0);
    check("arst_seed_valid", int'(seed_valid), 0);
    check("arst_service_err", int'(service_err), 0);
    check("arst_busy", int'(busy), 0);
    repeat (2) @(posedge Clk);
    #1;
    reset_n = 1'b1;
    ov_count = 0;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'(i % 3 == 0));
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_no_out", ov_count, 0);
    check("post_rst_seed_valid", int'(seed_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_descrambler.md
# rx_descrambler

- Receive-side counterpart of the TX scrambler in the 802.11a baseband chain.
- Takes the serial bit stream from the Viterbi decoder, recovers the 7-bit scrambler state from the first 7 SERVICE bits (transmitted as zeros), and descrambles the rest of the frame with the x^7 + x^4 + 1 LFSR.
- Strips the 16 SERVICE bits, optionally checks the 9 reserved SERVICE bits, and passes PSDU bits downstream one per valid cycle.

## Interface
- No parameters.
- Ports:
  - `Clk  in  1` – system clock, rising edge.
  - `reset_n  in  1` – asynchronous, active-low reset.
  - `start  in  1` – one-cycle pulse marking that the next accepted bit (including one in the same cycle) is SERVICE bit 0.
  - `stop  in  1` – end of frame; return to IDLE.
  - `in_valid  in  1` – `in_data` qualifier.
  - `in_data  in  1` – scrambled bit from the decoder.
  - `out_valid  out  1` – descrambled PSDU bit valid.
  - `out_data  out  1` – descrambled PSDU bit.
  - `sync_state  out  7` – LFSR state captured after SERVICE bit 6.
  - `seed_valid  out  1` – `sync_state` is valid for the current frame.
  - `service_err  out  1` – sticky flag: a reserved SERVICE bit descrambled to 1.
  - `busy  out  1` – high in any state except IDLE.

## Operation
- **States:** IDLE, ACQ, SVC, DATA. Internal signals: `lfsr[6:0]`, `bitcnt[3:0]`, feedback `fb = lfsr[6] ^ lfsr[3]`.
- **IDLE:** `in_valid` is ignored; no output.
- **ACQ** (SERVICE bits 0–6): on each `in_valid`, `lfsr <= {lfsr[5:0], in_data}` and `bitcnt` increments.
  - Nothing is output.
  - On the 7th bit (`bitcnt==6`), `sync_state` is loaded with the value `lfsr` takes, `seed_valid` is set, and the state moves to SVC.
- **SVC** (SERVICE bits 7–15): each `in_valid` computes `d = in_data ^ fb` and updates `lfsr <= {lfsr[5:0], fb}`.
  - `d` is not output.
  - `service_err` is set if `d==1` (see Configuration).
  - After the 16th SERVICE bit (`bitcnt==15`), the state moves to DATA.
- **DATA:** each `in_valid` produces `out_data <= in_data ^ fb`, `out_valid <= 1`, and `lfsr <= {lfsr[5:0], fb}`. This continues until `stop`.
- **`start`** is accepted in any state and has priority over `stop`. It moves the block to ACQ and clears `bitcnt`, `lfsr`, `seed_valid` and `service_err`. If `in_valid` is high in the same cycle, that bit is taken as SERVICE bit 0.
- **`stop`** moves the block to IDLE from any state. A bit presented in the same cycle as `stop` (without `start`) is discarded. `sync_state`, `seed_valid` and `service_err` hold their values until the next `start`.
- **`stop` during ACQ or SVC:** the frame is abandoned, no PSDU bits are emitted, and the flags keep their partial values.
- **`in_valid` low:** state, counter and `lfsr` hold.

## Timing
- **Reset values:** state IDLE; `lfsr`, `bitcnt`, `sync_state` = 0; `out_valid`, `out_data`, `seed_valid`, `service_err`, `busy` = 0.
- All outputs are registered.
- **Latency:** the DATA bit accepted in cycle N appears on `out_data`/`out_valid` in cycle N+1.
- `out_valid` is high for exactly one cycle per accepted DATA bit. It is 0 in the cycle after an idle input cycle.
- `seed_valid` rises in the cycle after SERVICE bit 6 is accepted. `service_err` rises in the cycle after the offending bit.
- The first PSDU bit is the 17th accepted bit after `start`. Its `out_valid` occurs one cycle after it is accepted.
- `busy` rises the cycle after `start` and falls the cycle after `stop`.
- Back-to-back operation is supported: one bit per cycle, no bubbles.

## Configuration
- **`RX_DESCRAMBLER_SERVICE_CHECK_EN` defined:** the reserved-bit check in SVC is compiled in and `service_err` behaves as specified above.
- **Not defined:** the check logic is removed, `service_err` is tied to 0, and all other behaviour is identical.

## Test plan
- **Seed recovery, all-ones seed:** after `start`, feed the 16-bit scrambled-zero SERVICE sequence `0000111 011110010`.
  - `sync_state = 7'b0000111`.
  - `seed_valid` = 1 after bit 7.
  - `service_err` = 0.
  - No `out_valid` is asserted during the 16 bits.
- **PSDU round trip:** TX scrambler with seed `7'b1011101` scrambles 16 zero bits followed by 64 random bits, fed continuously.
  - Output equals the 64 original bits exactly.
  - First `out_valid` occurs 17 cycles after the cycle `start` was applied with bit 0.
- **Gapped input:** same stream as the round trip, with `in_valid` deasserted every third cycle.
  - Output bit sequence is identical.
  - `out_valid` count = 64.
- **Reserved-bit error:** flip SERVICE bit 10 in the scrambled stream.
  - With the macro defined, `service_err` = 1 from the cycle after bit 10 and stays set until the next `start`.
  - Without the macro, `service_err` stays 0.
- **Restart and stop:** assert `start` mid-DATA, together with a new frame's bit 0.
  - The new frame decodes correctly.
  - `seed_valid` and `service_err` clear in the next cycle.
  - Asserting `stop` and `start` in the same cycle gives ACQ.
- **Async reset:** pull `reset_n` low mid-DATA, between clock edges.
  - All outputs go to 0 immediately.
  - After release, `in_valid` bits are ignored until `start`.
